// File: rtl/multi_seq_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// Contents: multi_state_t (FSM encoding), MULTI_DEFAULT_WIDTH (default operand width).
package multi_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} multi_state_t;

  localparam int unsigned MULTI_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/multi_seq_if.sv
// Request/result bundle of the sequential multiplier.
// master: start, a, b out; ready, busy, done, Pcirc, prod, ovf in.
// slave : the multiplier side (mirror of master).
interface multi_seq_if #(
  parameter int unsigned WIDTH = multi_pkg::MULTI_DEFAULT_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   Pcirc;
  logic [2*WIDTH-1:0] prod;
  logic               ovf;

  modport master (
    output start, a, b,
    input  ready, busy, done, Pcirc, prod, ovf
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, Pcirc, prod, ovf
  );

endinterface

// File: rtl/multi_seq_step.sv
// One shift-add iteration of the multiplier datapath (purely combinational).
// Inputs : acc, a_sh (2*WIDTH), b_sh (WIDTH).
// Outputs: acc_nx = acc + (b_sh[0] ? a_sh : 0), a_sh_nx = a_sh << 1, b_sh_nx = b_sh >> 1.
module multi_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] a_sh,
  input  logic [WIDTH-1:0]   b_sh,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [2*WIDTH-1:0] a_sh_nx,
  output logic [WIDTH-1:0]   b_sh_nx
);

  // acc never exceeds a*b < 2^(2*WIDTH), so the add cannot wrap
  always_comb begin
    acc_nx  = b_sh[0] ? (acc + a_sh) : acc;
    a_sh_nx = a_sh << 1;
    b_sh_nx = b_sh >> 1;
  end

endmodule

// File: rtl/multi_seq.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH steps.
// Ports: clk, rst (async, active-high), bus (multi_seq_if.slave):
//   start/a/b request, ready/busy/done status, prod (full), Pcirc (low WIDTH bits), ovf.
// Optional: define MULTI_SEQ_EARLY_TERM_EN to finish as soon as the remaining
//   multiplier bits are all zero (results unchanged, latency shorter).
module multi_seq
  import multi_pkg::*;
#(
  parameter int unsigned WIDTH = MULTI_DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  multi_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  multi_state_t   state;
  multi_state_t   state_nx;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;

  logic [PW-1:0]    acc_nx;
  logic [PW-1:0]    a_sh_nx;
  logic [WIDTH-1:0] b_sh_nx;

  logic accept_c;
  logic last_step_c;

  multi_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .a_sh    (a_sh),
    .b_sh    (b_sh),
    .acc_nx  (acc_nx),
    .a_sh_nx (a_sh_nx),
    .b_sh_nx (b_sh_nx)
  );

  // start is only honoured while not calculating
  assign accept_c = bus.start && (state != CALC);

  // the step taken with cnt == WIDTH-1 is the last one
`ifdef MULTI_SEQ_EARLY_TERM_EN
  assign last_step_c = (cnt == CNT_W'(WIDTH - 1)) || (b_sh_nx == '0);
`else
  assign last_step_c = (cnt == CNT_W'(WIDTH - 1));
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (last_step_c) state_nx = DONE;
      DONE:    state_nx = bus.start ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (accept_c) begin
      acc  <= '0;
      a_sh <= PW'(bus.a);
      b_sh <= bus.b;
      cnt  <= '0;
    end else if (state == CALC) begin
      acc  <= acc_nx;
      a_sh <= a_sh_nx;
      b_sh <= b_sh_nx;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // results load on DONE entry and hold until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.prod  <= '0;
      bus.Pcirc <= '0;
      bus.ovf   <= 1'b0;
    end else if ((state == CALC) && last_step_c) begin
      bus.prod  <= acc_nx;
      bus.Pcirc <= acc_nx[WIDTH-1:0];
      bus.ovf   <= |acc_nx[PW-1:WIDTH];
    end
  end

  // status flags registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.ready <= (state_nx != CALC);
      bus.busy  <= (state_nx == CALC);
      bus.done  <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_multi_seq.sv
// Self-checking bench for multi_seq at WIDTH=4 and WIDTH=8: drivers push the
// expected result of each accepted request; monitors compare on every done.
module tb_multi_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_seq_if #(.WIDTH(4)) b4 ();
  multi_seq_if #(.WIDTH(8)) b8 ();

  multi_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  multi_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    longint unsigned prod;
    longint unsigned pcirc;
    longint unsigned ovf;
    int              lat;
    int              acc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  longint unsigned hold4 = 0;
  longint unsigned hold8 = 0;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference: plain multiplication; latency from the position of b's top set bit
  function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                 input int w, input int acc);
    exp_t e;
    longint unsigned mask;
    int hi;
    mask    = (64'd1 << w) - 64'd1;
    e.prod  = a * b;
    e.pcirc = e.prod & mask;
    e.ovf   = (e.prod > mask) ? 1 : 0;
    hi = 0;
    for (int i = 0; i < w; i++) if (b[i]) hi = i;
`ifdef MULTI_SEQ_EARLY_TERM_EN
    e.lat = hi + 1;
`else
    e.lat = w;
`endif
    e.acc = acc;
    return e;
  endfunction

  // monitors
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst) begin
      q4.delete();
      hold4 = 0;
    end else if (b4.done) begin
      if (q4.size() == 0) chk("w4_unexpected_done", b4.done, 0);
      else begin
        e = q4.pop_front();
        chk("w4_prod",    b4.prod,  e.prod);
        chk("w4_pcirc",   b4.Pcirc, e.pcirc);
        chk("w4_ovf",     b4.ovf,   e.ovf);
        chk("w4_latency", cyc - e.acc, e.lat);
        hold4 = e.prod;
      end
    end else begin
      chk("w4_hold_prod",  b4.prod,  hold4);
      chk("w4_hold_pcirc", b4.Pcirc, hold4 & 64'hF);
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst) begin
      q8.delete();
      hold8 = 0;
    end else if (b8.done) begin
      if (q8.size() == 0) chk("w8_unexpected_done", b8.done, 0);
      else begin
        e = q8.pop_front();
        chk("w8_prod",    b8.prod,  e.prod);
        chk("w8_pcirc",   b8.Pcirc, e.pcirc);
        chk("w8_ovf",     b8.ovf,   e.ovf);
        chk("w8_latency", cyc - e.acc, e.lat);
        hold8 = e.prod;
      end
    end else begin
      chk("w8_hold_prod", b8.prod, hold8);
    end
  end

  // drivers: called at posedge+1
  task automatic issue4(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    while (!b4.ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!b4.ready) chk("w4_ready_timeout", b4.ready, 1);
    b4.start = 1'b1; b4.a = a; b4.b = b;
    @(posedge clk); #1;
    b4.start = 1'b0;
    q4.push_back(model(a, b, 4, cyc));
    chk("w4_busy_after_accept", b4.busy, 1);
    chk("w4_ready_after_accept", b4.ready, 0);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!b8.ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!b8.ready) chk("w8_ready_timeout", b8.ready, 1);
    b8.start = 1'b1; b8.a = a; b8.b = b;
    @(posedge clk); #1;
    b8.start = 1'b0;
    q8.push_back(model(a, b, 8, cyc));
    chk("w8_busy_after_accept", b8.busy, 1);
  endtask

  // start pulse while busy: must be ignored
  task automatic spur4(input logic [3:0] a, input logic [3:0] b);
    b4.start = 1'b1; b4.a = a; b4.b = b;
    @(posedge clk); #1;
    b4.start = 1'b0;
  endtask

  task automatic wait_done4();
    int n = 0;
    while (!b4.done && n < 100) begin @(posedge clk); #1; n++; end
    if (!b4.done) chk("w4_done_timeout", b4.done, 1);
  endtask

  initial begin
    int n;
    b4.start = 1'b0; b4.a = '0; b4.b = '0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", b4.ready, 1);
    chk("rst_busy",  b4.busy,  0);
    chk("rst_done",  b4.done,  0);
    chk("rst_prod",  b4.prod,  0);
    chk("rst_pcirc", b4.Pcirc, 0);
    chk("rst_ovf",   b4.ovf,   0);
    chk("rst_w8_ready", b8.ready, 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // directed WIDTH=4 cases
    issue4(4'd3, 4'd2);
    wait_done4();
    chk("w4_ready_in_done", b4.ready, 1);
    issue4(4'd15, 4'd15);
    issue4(4'd7, 4'd7);
    issue4(4'd8, 4'd0);
    issue4(4'd0, 4'd0);
    issue4(4'd4, 4'd5);
    spur4(4'd9, 4'd9);
    wait_done4();
    issue4(4'd2, 4'd3);           // accepted in the DONE cycle
    wait_done4();

    // asynchronous reset in the middle of a calculation
    issue4(4'd4, 4'd7);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_ready", b4.ready, 1);
    chk("midrst_busy",  b4.busy,  0);
    chk("midrst_done",  b4.done,  0);
    chk("midrst_prod",  b4.prod,  0);
    chk("midrst_pcirc", b4.Pcirc, 0);
    chk("midrst_ovf",   b4.ovf,   0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    issue4(4'd5, 4'd3);
    wait_done4();

    // randomized WIDTH=4 traffic with gaps and ignored starts
    for (int i = 0; i < 40; i++) begin
      issue4(4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) spur4(4'($urandom), 4'($urandom));
      n = $urandom_range(0, 2);
      if (n > 0) begin
        wait_done4();
        repeat (n) begin @(posedge clk); #1; end
      end
    end

    // WIDTH=8
    issue8(8'd255, 8'd255);
    issue8(8'd0, 8'd200);
    issue8(8'd16, 8'd15);
    for (int i = 0; i < 12; i++) issue8(8'($urandom), 8'($urandom));

    n = 0;
    while ((q4.size() + q8.size()) != 0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_pending", q4.size() + q8.size(), 0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
